// File: rtl/dsp_pkg.sv
// Shared constants for the DSP add/sub pipeline: slice width, opcode
// encodings and bit positions inside the {carry, overflow, zero} flags.
package dsp_pkg;

    localparam int   DSP_SLICE  = 16;

    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;

    // Flag vector layout: flags = {carry, overflow, zero}.
    localparam int   FLAG_ZERO  = 0;
    localparam int   FLAG_OVF   = 1;
    localparam int   FLAG_CARRY = 2;
    localparam int   FLAG_W     = 3;

endpackage

// File: rtl/dsp_slice16.sv
// One 16-bit carry-chain slice: purely combinational add with carry-in.
// Also reports the carry into the slice MSB so the top slice can derive
// signed overflow. All pipeline registers live in the parent.
module dsp_slice16
    import dsp_pkg::*;
(
    input  logic [DSP_SLICE-1:0] i_a,
    input  logic [DSP_SLICE-1:0] i_b,
    input  logic                 i_cin,
    output logic [DSP_SLICE-1:0] o_sum,
    output logic                 o_cout,
    output logic                 o_cmsb
);

    logic [DSP_SLICE:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{DSP_SLICE{1'b0}}, i_cin};
    assign o_sum  = w_full[DSP_SLICE-1:0];
    assign o_cout = w_full[DSP_SLICE];
    // The carry that entered the MSB is recoverable from the MSB sum bit.
    assign o_cmsb = o_sum[DSP_SLICE-1] ^ i_a[DSP_SLICE-1] ^ i_b[DSP_SLICE-1];

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor built from NS = WIDTH/16 carry-chain
// slices, one slice per stage, with skewed operands and a valid/ready
// handshake. All stages advance together when the output is free or taken.
// Optional build macro: DSP_ADDSUB_FLAGS_EN adds the flags port
// {carry, overflow, zero} and its registers.
module dsp_addsub_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = DSP_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef DSP_ADDSUB_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] flags
`endif
);

    localparam int NS = WIDTH / SLICE;

    logic             w_adv;
    logic [NS-1:0]    r_valid;
    logic [WIDTH-1:0] w_b_eff;
    logic [NS-1:0]    w_cout_vec;
    logic [NS-1:0]    w_cmsb_vec;
    logic [WIDTH-1:0] w_res_final;
    logic [WIDTH-1:0] r_result;
    logic             w_unused;

    // Whole pipeline moves as one; a held output freezes every stage.
    assign w_adv     = !r_valid[NS-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[NS-1];

    // Subtraction is A + ~B + 1: invert B once at the input, carry-in on slice 0.
    assign w_b_eff = (op == OP_SUB) ? ~b_in : b_in;

    // Valid shift register: cleared by reset, bubbles travel like data.
    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its neighbour's pre-edge value, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < NS; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    for (genvar k = 0; k < NS; k++) begin : g_stage
        // Operand bits still to be consumed when reaching this stage.
        localparam int REM = WIDTH - SLICE * k;

        logic [REM-1:0]           w_a_rem;
        logic [REM-1:0]           w_b_rem;
        logic                     w_cin;
        logic [SLICE-1:0]         w_sum;
        logic [SLICE*(k+1)-1:0]   w_res_next;

        if (k == 0) begin : g_src
            assign w_a_rem    = a_in;
            assign w_b_rem    = w_b_eff;
            assign w_cin      = (op == OP_SUB);
            assign w_res_next = w_sum;
        end else begin : g_src
            assign w_a_rem    = g_stage[k-1].g_skew.r_a_hi;
            assign w_b_rem    = g_stage[k-1].g_skew.r_b_hi;
            assign w_cin      = g_stage[k-1].g_skew.r_carry;
            assign w_res_next = {w_sum, g_stage[k-1].g_skew.r_res};
        end

        dsp_slice16 u_slice (
            .i_a    (w_a_rem[SLICE-1:0]),
            .i_b    (w_b_rem[SLICE-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_sum),
            .o_cout (w_cout_vec[k]),
            .o_cmsb (w_cmsb_vec[k])
        );

        if (k < NS - 1) begin : g_skew
            logic [REM-SLICE-1:0]   r_a_hi;
            logic [REM-SLICE-1:0]   r_b_hi;
            logic                   r_carry;
            logic [SLICE*(k+1)-1:0] r_res;

            // Stage register: finished low slices, slice carry, untouched high operands.
            // NOTE: data registers carry no reset; only the valid bits define
            // whether their contents mean anything.
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a_hi  <= w_a_rem[REM-1:SLICE];
                    r_b_hi  <= w_b_rem[REM-1:SLICE];
                    r_carry <= w_cout_vec[k];
                    r_res   <= w_res_next;
                end
            end
        end else begin : g_last
            assign w_res_final = w_res_next;
        end
    end

    // Only the top slice's carries reach the flags; the rest end here.
    assign w_unused = ^{w_cout_vec, w_cmsb_vec};

`ifdef DSP_ADDSUB_FLAGS_EN
    logic [FLAG_W-1:0] r_flags;
`endif

    // Final stage: capture the assembled result (and flags) on advance.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_result <= w_res_final;
`ifdef DSP_ADDSUB_FLAGS_EN
            r_flags[FLAG_CARRY] <= w_cout_vec[NS-1];
            r_flags[FLAG_OVF]   <= w_cout_vec[NS-1] ^ w_cmsb_vec[NS-1];
            r_flags[FLAG_ZERO]  <= (w_res_final == '0);
`endif
        end
    end

    // Outputs read as zero whenever nothing valid is presented.
    assign result = out_valid ? r_result : '0;
`ifdef DSP_ADDSUB_FLAGS_EN
    assign flags  = out_valid ? r_flags : '0;
`endif

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Self-checking bench for dsp_addsub_pipe at WIDTH=32 and WIDTH=64.
// Expected results come from a plain-arithmetic model pushed into a
// scoreboard at acceptance; per-DUT monitors pop and compare on each
// output handshake. Flags are checked when DSP_ADDSUB_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_dsp_addsub_pipe;
    import dsp_pkg::*;

    localparam int W32 = 32;
    localparam int W64 = 64;
    localparam int NS32 = W32 / 16;
    localparam int NS64 = W64 / 16;

    typedef struct {
        logic [127:0] res;
        logic [2:0]   flg;
        int           cyc;
        bit           chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           s32_in_valid, s32_in_ready, s32_op, s32_out_valid, s32_out_ready;
    logic [W32-1:0] s32_a, s32_b, s32_result;
    logic           s64_in_valid, s64_in_ready, s64_op, s64_out_valid, s64_out_ready;
    logic [W64-1:0] s64_a, s64_b, s64_result;
`ifdef DSP_ADDSUB_FLAGS_EN
    logic [2:0]     s32_flags, s64_flags;
`endif

    dsp_addsub_pipe #(.WIDTH(W32), .SLICE(16)) u_dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s32_in_valid),
        .in_ready  (s32_in_ready),
        .a_in      (s32_a),
        .b_in      (s32_b),
        .op        (s32_op),
        .out_valid (s32_out_valid),
        .out_ready (s32_out_ready),
        .result    (s32_result)
`ifdef DSP_ADDSUB_FLAGS_EN
        ,
        .flags     (s32_flags)
`endif
    );

    dsp_addsub_pipe #(.WIDTH(W64), .SLICE(16)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s64_in_valid),
        .in_ready  (s64_in_ready),
        .a_in      (s64_a),
        .b_in      (s64_b),
        .op        (s64_op),
        .out_valid (s64_out_valid),
        .out_ready (s64_out_ready),
        .result    (s64_result)
`ifdef DSP_ADDSUB_FLAGS_EN
        ,
        .flags     (s64_flags)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   lat_chk  = 1'b1;
    exp_t q32[$];
    exp_t q64[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: modular add/sub plus unsigned carry and signed overflow by definition.
    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                   input logic op, input int w);
        exp_t         e;
        logic [128:0] full;
        logic [127:0] mask;
        logic [127:0] am, bm;
        logic         carry, ovf, sa, sb, sr;
        mask = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        am = a & mask;
        bm = b & mask;
        if (op == OP_ADD) begin
            full  = {1'b0, am} + {1'b0, bm};
            carry = full[w];
        end else begin
            full  = {1'b0, am} - {1'b0, bm};
            carry = (am >= bm);
        end
        e.res = full[127:0] & mask;
        sa = am[w-1];
        sb = bm[w-1];
        sr = e.res[w-1];
        ovf = (op == OP_ADD) ? (sa == sb && sr != sa) : (sa != sb && sr != sa);
        e.flg = {carry, ovf, (e.res == '0)};
        e.cyc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    task automatic issue32(input logic [W32-1:0] a, input logic [W32-1:0] b, input logic op);
        bit done = 1'b0;
        s32_in_valid = 1'b1;
        s32_a = a;
        s32_b = b;
        s32_op = op;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s32_in_ready && !rst) begin
                exp_t e;
                e = model(128'(a), 128'(b), op, W32);
                e.cyc = cyc;
                e.chk_lat = lat_chk;
                q32.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s32_in_valid = 1'b0;
        if (!done) check("issue32_accept_timeout", 0, 1);
    endtask

    task automatic issue64(input logic [W64-1:0] a, input logic [W64-1:0] b, input logic op);
        bit done = 1'b0;
        s64_in_valid = 1'b1;
        s64_a = a;
        s64_b = b;
        s64_op = op;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (s64_in_ready && !rst) begin
                exp_t e;
                e = model(128'(a), 128'(b), op, W64);
                e.cyc = cyc;
                e.chk_lat = lat_chk;
                q64.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s64_in_valid = 1'b0;
        if (!done) check("issue64_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int i = 0;
        while ((q32.size() != 0 || q64.size() != 0) && i < 100) begin
            @(posedge clk);
            i++;
        end
        check("drain_queues_empty", 128'(q32.size() + q64.size()), 0);
        #1;
    endtask

    // Output monitor, 32-bit DUT: pop and compare on every handshake.
    always @(negedge clk) begin
        if (rst) begin
            q32.delete();
        end else if (s32_out_valid && s32_out_ready) begin
            if (q32.size() == 0) begin
                check("s32_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                check("s32_result", 128'(s32_result), e.res);
`ifdef DSP_ADDSUB_FLAGS_EN
                check("s32_flags", 128'(s32_flags), 128'(e.flg));
`endif
                if (e.chk_lat) check("s32_latency", 128'(cyc - e.cyc), NS32);
            end
        end
    end

    // Output monitor, 64-bit DUT.
    always @(negedge clk) begin
        if (rst) begin
            q64.delete();
        end else if (s64_out_valid && s64_out_ready) begin
            if (q64.size() == 0) begin
                check("s64_unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = q64.pop_front();
                check("s64_result", 128'(s64_result), e.res);
`ifdef DSP_ADDSUB_FLAGS_EN
                check("s64_flags", 128'(s64_flags), 128'(e.flg));
`endif
                if (e.chk_lat) check("s64_latency", 128'(cyc - e.cyc), NS64);
            end
        end
    end

    initial begin
        int t0;
        logic [W32-1:0] pa, pb;
        logic           pop;

        rst = 1'b1;
        s32_in_valid = 1'b0; s32_a = '0; s32_b = '0; s32_op = OP_ADD; s32_out_ready = 1'b1;
        s64_in_valid = 1'b0; s64_a = '0; s64_b = '0; s64_op = OP_ADD; s64_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid32", 128'(s32_out_valid), 0);
        check("rst_in_ready32",  128'(s32_in_ready), 1);
        check("rst_result32",    128'(s32_result), 0);
        check("rst_out_valid64", 128'(s64_out_valid), 0);
        check("rst_result64",    128'(s64_result), 0);
`ifdef DSP_ADDSUB_FLAGS_EN
        check("rst_flags32", 128'(s32_flags), 0);
        check("rst_flags64", 128'(s64_flags), 0);
`endif
        @(posedge clk);
        #1;

        // Directed cases: slice-boundary carry, borrow, signed overflow, wrap.
        issue32(32'h0001_FFFF, 32'h0000_0001, OP_ADD);
        issue32(32'd5, 32'd7, OP_SUB);
        issue32(32'h8000_0000, 32'h0000_0001, OP_SUB);
        issue32(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
        issue32(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
        issue32(32'h1234_5678, 32'h1234_5678, OP_SUB);
        drain();

        // Back-to-back stream of 8 random pairs: one acceptance per cycle.
        t0 = cyc;
        for (int i = 0; i < 8; i++) issue32($urandom, $urandom, 1'($urandom_range(0, 1)));
        check("stream_accept_cycles", 128'(cyc - t0), 8);
        // A bubble between two operations.
        issue32($urandom, $urandom, OP_ADD);
        @(posedge clk);
        #1;
        issue32($urandom, $urandom, OP_SUB);
        drain();

        // Back-pressure: fill the pipeline with out_ready low, hold 5 cycles.
        lat_chk = 1'b0;
        s32_out_ready = 1'b0;
        for (int i = 0; i < NS32; i++) issue32($urandom, $urandom, 1'($urandom_range(0, 1)));
        pa = $urandom; pb = $urandom; pop = 1'($urandom_range(0, 1));
        s32_in_valid = 1'b1; s32_a = pa; s32_b = pb; s32_op = pop;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 128'(s32_in_ready), 0);
            check("stall_out_valid", 128'(s32_out_valid), 1);
            if (q32.size() != 0) check("stall_result_held", 128'(s32_result), q32[0].res);
            else check("stall_queue_nonempty", 0, 1);
            @(posedge clk);
            #1;
        end
        s32_out_ready = 1'b1;
        lat_chk = 1'b1;
        issue32(pa, pb, pop);
        drain();

        // Reset with two operations in flight: neither may ever come out.
        issue32($urandom, $urandom, OP_ADD);
        issue32($urandom, $urandom, OP_SUB);
        rst = 1'b1;
        s32_out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s32_out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid32", 128'(s32_out_valid), 0);
        check("midrst_in_ready32",  128'(s32_in_ready), 1);
        check("midrst_result32",    128'(s32_result), 0);
        repeat (6) @(posedge clk);
        #1;
        issue32($urandom, $urandom, OP_ADD);
        issue32(32'h0, 32'h0, OP_SUB);
        drain();

        // 64-bit build: full-width wrap, latency 4, then random traffic.
        issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD);
        issue64(64'h0, 64'h1, OP_SUB);
        issue64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, OP_ADD);
        for (int i = 0; i < 6; i++) issue64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_addsub_pipe.md
DSP_ADDSUB_PIPE -- requirements
Module: dsp_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are multiples of 16, from 16 to 128.
REQ-002 SHALL have parameter SLICE, default 16, carry-chain slice width; fixed at 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-007 SHALL have port a_in, input, WIDTH bits: operand A.
REQ-008 SHALL have port b_in, input, WIDTH bits: operand B.
REQ-009 SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is present.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 SHALL have port result, output, WIDTH bits: the sum or difference, modulo 2^WIDTH.
REQ-013 SHALL have port flags, output, 3 bits: {carry, overflow, zero}; present only under REQ-030.

Function
REQ-014 SHALL contain NS = WIDTH/16 pipeline stages; stage k computes slice k using the registered carry from stage k-1.
REQ-015 SHALL carry the bit-inverted B and carry-in 1 into slice 0 when op=1; otherwise B is carried unmodified with carry-in 0.
REQ-016 SHALL skew operands: slice k of A/B/op is delayed k cycles; result slices already computed are delayed to align at stage NS-1.
REQ-017 SHALL give a latency of exactly NS cycles from acceptance (in_valid & in_ready) to out_valid when out_ready is held 1.
REQ-018 SHALL advance all stages together on adv = !out_valid | out_ready; in_ready = adv, combinationally.
REQ-019 SHALL freeze every stage register, including the valid bits and the skew registers, when adv=0.
REQ-020 SHALL keep result stable while out_valid=1 and out_ready=0.
REQ-021 SHALL sustain a throughput of one result per cycle when in_valid=out_ready=1 continuously.
REQ-022 SHALL propagate a bubble when in_valid=0 while adv=1: a valid bit of 0 enters stage 0; bubbles are not compressed.
REQ-023 SHALL define carry as the carry-out of the top slice; for subtraction carry=1 means no borrow (A>=B unsigned).
REQ-024 SHALL define overflow as the signed overflow: carry into the MSB XOR carry out of the MSB.
REQ-025 SHALL define zero as result==0, evaluated registered in the last stage.
REQ-026 SHALL handle wrap-around: A=2^WIDTH-1 plus B=1 gives result=0, carry=1, zero=1.

Reset
REQ-027 SHALL clear all valid bits on rst=1; out_valid=0 the cycle after reset, and in_ready=1.
REQ-028 SHALL drive result=0 and flags=0 while out_valid=0 following reset; data registers need no reset otherwise.
REQ-029 SHALL discard in-flight operations on reset mid-operation; no result for them ever appears, and rst overrides adv.

Configuration
REQ-030 SHALL, with macro DSP_ADDSUB_FLAGS_EN defined, implement the flags port and the carry/overflow/zero registers.
REQ-031 SHALL, without DSP_ADDSUB_FLAGS_EN, omit the flags port and its logic, leaving result and the handshake unchanged.

Structure
REQ-032 SHALL take from shared package dsp_pkg: the constants DSP_SLICE=16, OP_ADD=1'b0 and OP_SUB=1'b1, and the flag bit-index constants.
REQ-033 SHALL instantiate sub-module dsp_slice16 NS times; each is a 16-bit add with carry-in, carry-out and MSB-carry outputs, combinational, with the registers held in the parent.

Verification
REQ-034 SHALL cover WIDTH=32: A=0x0001_FFFF, B=0x0000_0001, op=0 -> result 0x0002_0000 after 2 cycles, carry=0, overflow=0, zero=0.
REQ-035 SHALL cover WIDTH=32: A=5, B=7, op=1 -> result 0xFFFF_FFFE, carry=0, overflow=0; then A=0x8000_0000, B=1, op=1 -> 0x7FFF_FFFF, overflow=1.
REQ-036 SHALL cover a back-to-back stream of 8 random pairs with out_ready=1 -> 8 results in order, one per cycle, matching the model.
REQ-037 SHALL cover out_ready=0 for 5 cycles with the pipeline full -> in_ready=0, result held constant, no loss and no duplication after release.
REQ-038 SHALL cover rst asserted for 1 cycle with 2 operations in flight -> out_valid=0 next cycle, and neither result ever emitted.
REQ-039 SHALL cover WIDTH=64 with 0xFFFF_FFFF_FFFF_FFFF + 1 -> result 0, carry=1, zero=1, latency 4, in both macro builds (flags checked only when defined).
